// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// The operands are split into NG = WIDTH/GROUP lookahead groups. An input rank
// captures the beat, and each of the following NG ranks resolves one group
// using the carry registered by the rank before it. A beat accepted at edge N
// is therefore presented after edge N+NG.
// Optional feature: define PIPELINED_CLA_OVF_EN to build the registered signed
// overflow flag. Without it, ovf is tied to 0.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    typedef struct packed {
        logic [GROUP-1:0] s;
        logic             co;
    } grp_res_t;

    // GROUP-bit carry-lookahead: every internal carry is expanded directly
    // from the generate/propagate terms and the group carry-in.
    function automatic grp_res_t cla_group(input logic [GROUP-1:0] x,
                                           input logic [GROUP-1:0] y,
                                           input logic             ci);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             pp;
        grp_res_t         r;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
        r.s  = p ^ c[GROUP-1:0];
        r.co = c[GROUP];
        return r;
    endfunction

    // Rank k holds the beat that stage k resolves next: full operands, with the
    // upper groups still pending, the lower sum groups already resolved, and
    // the carry into group k.
    logic [WIDTH-1:0] op_a     [NG];
    logic [WIDTH-1:0] op_b     [NG];
    logic [WIDTH-1:0] part     [NG];
    logic             carry    [NG];
    logic [NG-1:0]    vld;

    logic [WIDTH-1:0] nxt_part [NG];
    logic             nxt_carry[NG];
    grp_res_t         grp      [NG];

    logic adv;

    // Every stage moves together. The whole pipe stalls only when a presented
    // result is not taken.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Resolve group k of rank k, then merge it into the partial sum.
    always_comb begin
        for (int k = 0; k < NG; k++) begin
            // NOTE: every always_comb output gets a default before any
            // conditional or partial update, so no latch can be inferred.
            nxt_part[k]  = part[k];
            grp[k]       = cla_group(op_a[k][k*GROUP +: GROUP],
                                     op_b[k][k*GROUP +: GROUP], carry[k]);
            nxt_part[k][k*GROUP +: GROUP] = grp[k].s;
            nxt_carry[k] = grp[k].co;
        end
    end

    // Datapath ranks: capture the effective operands, then shift the beat down
    // the pipe with the newly resolved group and carry.
    always_ff @(posedge clk) begin
        // NOTE: the data ranks are not reset. The valid bits alone decide
        // whether a slot holds a beat, so clearing wide data would only add
        // reset fan-out.
        if (adv) begin
            op_a[0]  <= a;
            op_b[0]  <= sub ? ~b : b;
            carry[0] <= sub | cin;
            part[0]  <= '0;
            for (int k = 1; k < NG; k++) begin
                op_a[k]  <= op_a[k-1];
                op_b[k]  <= op_b[k-1];
                carry[k] <= nxt_carry[k-1];
                part[k]  <= nxt_part[k-1];
            end
        end
    end

    // Valid bits and the output register. The output keeps the last result
    // while a bubble passes through, and holds it during a stall.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments, so each
        // rank samples the pre-edge value of the rank before it.
        if (rst) begin
            vld       <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (adv) begin
            vld[0] <= in_valid;
            for (int k = 1; k < NG; k++) begin
                vld[k] <= vld[k-1];
            end
            out_valid <= vld[NG-1];
            if (vld[NG-1]) begin
                sum  <= nxt_part[NG-1];
                cout <= nxt_carry[NG-1];
            end
        end
    end

`ifdef PIPELINED_CLA_OVF_EN
    // Signed overflow for the beat in the last rank. That rank still holds the
    // operand MSBs, so the flag needs no extra tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (adv && vld[NG-1]) begin
            ovf <= (op_a[NG-1][WIDTH-1] == op_b[NG-1][WIDTH-1]) &&
                   (nxt_part[NG-1][WIDTH-1] != op_a[NG-1][WIDTH-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder
// Directed vectors for the default 16-bit / 4-bit-group configuration, plus
// hand-written sequences for reset, backpressure and reset during flight.
module tb_pipelined_cla_adder;

    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int LAT   = WIDTH / GROUP;
`ifdef PIPELINED_CLA_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] got[$];

    pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every delivered result, in order.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(sum);
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock, then settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a single beat, then count the cycles until the result appears.
    task automatic send_one(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic vcin, input logic vsub, output int lat);
        a        = va;
        b        = vb;
        cin      = vcin;
        sub      = vsub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
    endtask

    vec_t vecs[10];
    int   lat;

    initial begin
        vecs[0] = '{16'h0005, 16'h0006, 1'b1, 1'b0, 16'h000C, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[6] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h000A, 16'h0003, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h0001;
        b         = 16'h0001;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        // Reset held for two cycles while beats are offered.
        step();
        step();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        rst      = 1'b0;
        in_valid = 1'b0;
        got.delete();
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (out_valid) seen++;
            end
            check("rst no stale out_valid", 32'(seen), 32'd0);
            check("rst no stale result", 32'(got.size()), 32'd0);
        end

        // Table-driven single beats: latency and result.
        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(OVF_EN & vecs[i].exp_ovf));
            step();
        end

        // Backpressure: six back-to-back beats, with a 3-cycle stall on the first result.
        repeat (3) step();
        got.delete();
        begin
            int               sent       = 0;
            int               stall_left = 0;
            bit               stalled    = 1'b0;
            logic [WIDTH-1:0] snap_sum   = '0;
            logic             acc;
            for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
                if (out_valid && !stalled) begin
                    stalled    = 1'b1;
                    stall_left = 3;
                    snap_sum   = sum;
                end
                out_ready = (stall_left == 0);
                in_valid  = (sent < 6);
                a         = WIDTH'(sent);
                b         = WIDTH'(sent);
                cin       = 1'b0;
                sub       = 1'b0;
                #1;
                if (stall_left > 0) begin
                    check($sformatf("stall in_ready c%0d", cyc), 32'(in_ready), 32'd0);
                    check($sformatf("stall out_valid c%0d", cyc), 32'(out_valid), 32'd1);
                    check($sformatf("stall sum hold c%0d", cyc), 32'(sum), 32'(snap_sum));
                end
                acc = in_valid && in_ready;
                step();
                if (acc) sent++;
                if (stall_left > 0) stall_left--;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("bp result count", 32'(got.size()), 32'd6);
            for (int i = 0; i < 6; i++) begin
                check($sformatf("bp result %0d", i),
                      (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(2 * i));
            end
        end

        // Reset during flight: three beats accepted, then reset one idle cycle later.
        repeat (3) step();
        got.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = WIDTH'(16'h0100 + i);
            b        = 16'h0001;
            step();
        end
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (out_valid) seen++;
            end
            check("midrst no out_valid", 32'(seen), 32'd0);
            check("midrst no results", 32'(got.size()), 32'd0);
        end
        send_one(16'd100, 16'd23, 1'b0, 1'b0, lat);
        check("midrst next latency", 32'(lat), 32'(LAT));
        check("midrst next sum", 32'(sum), 32'd123);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
